// File: rtl/s_to_p_stream_converter.sv
// Serial-to-parallel word packer with ready/valid handshakes on both sides.
// Packs P_LENGTH/S_LENGTH input beats into one vector; ilast closes a frame early, zero padded.
module s_to_p_stream_converter #(
  parameter int DATA_WIDTH = 32,
  parameter int S_LENGTH   = 2,
  parameter int P_LENGTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fct,
  input  logic                                 ien,
  output logic                                 irdy,
  input  logic [0:S_LENGTH-1][DATA_WIDTH-1:0]  idata,
  input  logic                                 ilast,
  output logic                                 oen,
  input  logic                                 ordy,
  output logic [0:P_LENGTH-1][DATA_WIDTH-1:0]  odata,
  output logic [0:P_LENGTH-1]                  omask,
  output logic                                 olast,
  output logic                                 finished
);

  localparam int K  = P_LENGTH / S_LENGTH;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  generate
    if (S_LENGTH < 1 || (P_LENGTH % S_LENGTH) != 0) begin : g_bad_params
      $error("P_LENGTH must be a positive integer multiple of S_LENGTH");
    end
  endgenerate

  logic [CW-1:0]                         cnt_q, cnt_d;
  logic [0:P_LENGTH-1][DATA_WIDTH-1:0]   acc_q, acc_d, acc_m;
  logic [0:P_LENGTH-1]                   mask_q, mask_d, mask_m;
  logic [0:P_LENGTH-1][DATA_WIDTH-1:0]   odata_q, odata_d;
  logic [0:P_LENGTH-1]                   omask_q, omask_d;
  logic                                  oen_q, oen_d;
  logic                                  olast_q, olast_d;
  logic                                  finished_q, finished_d;

  logic xfer_in;
  logic xfer_out;
  logic complete;

  assign irdy     = fct && (!oen_q || ordy);
  assign xfer_in  = ien && irdy;
  assign xfer_out = oen_q && ordy;
  assign complete = xfer_in && ((cnt_q == CW'(K - 1)) || ilast);

  // Accumulator with the current beat merged into the lanes selected by cnt.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_beat
      for (genvar gj = 0; gj < S_LENGTH; gj++) begin : g_lane
        logic lane_wr;
        assign lane_wr = xfer_in && (cnt_q == CW'(gi));
        assign acc_m[gi*S_LENGTH+gj]  = lane_wr ? idata[gj] : acc_q[gi*S_LENGTH+gj];
        assign mask_m[gi*S_LENGTH+gj] = lane_wr | mask_q[gi*S_LENGTH+gj];
      end
    end
  endgenerate

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mask_d     = mask_q;
    odata_d    = odata_q;
    omask_d    = omask_q;
    olast_d    = olast_q;
    oen_d      = oen_q && !ordy;
    finished_d = xfer_out && olast_q;

    if (complete) begin
      // A completing beat may land in the same cycle the old vector drains.
      odata_d = acc_m;
      omask_d = mask_m;
      olast_d = ilast;
      oen_d   = 1'b1;
      cnt_d   = '0;
      acc_d   = '0;
      mask_d  = '0;
    end else if (xfer_in) begin
      acc_d  = acc_m;
      mask_d = mask_m;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      mask_q     <= '0;
      odata_q    <= '0;
      omask_q    <= '0;
      olast_q    <= 1'b0;
      oen_q      <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mask_q     <= mask_d;
      odata_q    <= odata_d;
      omask_q    <= omask_d;
      olast_q    <= olast_d;
      oen_q      <= oen_d;
      finished_q <= finished_d;
    end
  end

  assign oen      = oen_q;
  assign odata    = odata_q;
  assign omask    = omask_q;
  assign olast    = olast_q;
  assign finished = finished_q;

endmodule
